// File: rtl/tcp_rx_arbiter.sv
// Packet-granular round-robin arbiter feeding one TCP deframer from N_PORTS
// AXI-Stream sources, with latched length/port metadata and a length check.
module tcp_rx_arbiter #(
    parameter  int N_PORTS    = 4,
    parameter  int AXIS_BYTES = 4,
    localparam int PORT_W     = $clog2(N_PORTS)
) (
    input  logic                          clk,
    input  logic                          sresetn,
    input  logic [N_PORTS-1:0]            axis_i_tvalid,
    output logic [N_PORTS-1:0]            axis_i_tready,
    input  logic [N_PORTS*AXIS_BYTES*8-1:0] axis_i_tdata,
    input  logic [N_PORTS-1:0]            axis_i_tlast,
    input  logic [N_PORTS*16-1:0]         axis_i_length_bytes,
    output logic                          axis_o_tvalid,
    input  logic                          axis_o_tready,
    output logic [AXIS_BYTES*8-1:0]       axis_o_tdata,
    output logic                          axis_o_tlast,
    output logic [15:0]                   axis_o_length_bytes,
    output logic [PORT_W-1:0]             axis_o_port_id,
    output logic                          len_err,
    output logic                          busy
);

    localparam int DATA_W = AXIS_BYTES * 8;

    typedef enum logic {
        IDLE,
        PASS
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   grant_q, grant_d;
    logic [PORT_W-1:0]   last_grant_q, last_grant_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         word_ctr_q, word_ctr_d;
    logic                len_err_q, len_err_d;

    logic                req_found;
    logic [PORT_W-1:0]   req_port;
    logic [16:0]         expected_words;
    logic [16:0]         beat_count;

    // Round-robin scan starting just after the last granted port.
    // NOTE: every variable driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        req_found = 1'b0;
        req_port  = '0;
        for (int i = 1; i <= N_PORTS; i++) begin
            if (!req_found && axis_i_tvalid[(int'(last_grant_q) + i) % N_PORTS]) begin
                req_found = 1'b1;
                req_port  = PORT_W'((int'(last_grant_q) + i) % N_PORTS);
            end
        end
    end

    assign expected_words = ({1'b0, len_q} + 17'd3) >> 2;
    assign beat_count     = {1'b0, word_ctr_q} + 17'd1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        len_d         = len_q;
        word_ctr_d    = word_ctr_q;
        len_err_d     = 1'b0;
        axis_i_tready = '0;
        axis_o_tvalid = 1'b0;
        axis_o_tdata  = '0;
        axis_o_tlast  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_found) begin
                    grant_d      = req_port;
                    last_grant_d = req_port;
                    len_d        = axis_i_length_bytes[int'(req_port)*16 +: 16];
                    word_ctr_d   = '0;
                    state_d      = PASS;
                end
            end
            PASS: begin
                axis_o_tvalid          = axis_i_tvalid[grant_q];
                axis_o_tdata           = axis_i_tdata[int'(grant_q)*DATA_W +: DATA_W];
                axis_o_tlast           = axis_i_tlast[grant_q];
                axis_i_tready[grant_q] = axis_o_tready;
                if (axis_o_tvalid && axis_o_tready) begin
                    if (word_ctr_q != 16'hFFFF) begin
                        word_ctr_d = word_ctr_q + 16'd1;
                    end
                    // Leaving on tlast forces one idle bubble before the next grant.
                    if (axis_o_tlast) begin
                        state_d   = IDLE;
                        len_err_d = (beat_count != expected_words);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge sresetn) begin
        if (!sresetn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= PORT_W'(N_PORTS - 1);
            len_q        <= '0;
            word_ctr_q   <= '0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            word_ctr_q   <= word_ctr_d;
            len_err_q    <= len_err_d;
        end
    end

    assign axis_o_length_bytes = len_q;
    assign axis_o_port_id      = grant_q;
    assign len_err             = len_err_q;
    assign busy                = (state_q == PASS);

endmodule

// File: tb/tb_tcp_rx_arbiter.sv
// Scoreboard bench for tcp_rx_arbiter: per-port packet sources, a monitor that
// pops expected beats on every output handshake, and one task per scenario.
module tb_tcp_rx_arbiter;

    localparam int N = 4;

    logic            clk;
    logic            sresetn;
    logic [N-1:0]    axis_i_tvalid;
    logic [N-1:0]    axis_i_tready;
    logic [N*32-1:0] axis_i_tdata;
    logic [N-1:0]    axis_i_tlast;
    logic [N*16-1:0] axis_i_length_bytes;
    logic            axis_o_tvalid;
    logic            axis_o_tready;
    logic [31:0]     axis_o_tdata;
    logic            axis_o_tlast;
    logic [15:0]     axis_o_length_bytes;
    logic [1:0]      axis_o_port_id;
    logic            len_err;
    logic            busy;

    tcp_rx_arbiter #(.N_PORTS(N), .AXIS_BYTES(4)) dut (
        .clk                 (clk),
        .sresetn             (sresetn),
        .axis_i_tvalid       (axis_i_tvalid),
        .axis_i_tready       (axis_i_tready),
        .axis_i_tdata        (axis_i_tdata),
        .axis_i_tlast        (axis_i_tlast),
        .axis_i_length_bytes (axis_i_length_bytes),
        .axis_o_tvalid       (axis_o_tvalid),
        .axis_o_tready       (axis_o_tready),
        .axis_o_tdata        (axis_o_tdata),
        .axis_o_tlast        (axis_o_tlast),
        .axis_o_length_bytes (axis_o_length_bytes),
        .axis_o_port_id      (axis_o_port_id),
        .len_err             (len_err),
        .busy                (busy)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [1:0]  port;
        logic [15:0] len;
        logic        err;
    } beat_t;

    beat_t       sb[$];
    int          hs_log[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          err_pulses = 0;

    logic [31:0] pdata [N][64];
    int          plen [N];
    logic [15:0] plen_bytes [N];
    int          ptr [N];
    bit          active [N];
    bit          cur_valid [N];
    logic [N-1:0] hs_seen = '0;
    bit          gaps = 1'b0;
    bit          rand_ready = 1'b0;
    bit          pend_last = 1'b0;
    logic        pend_err = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sources: one beat per port in flight, tvalid held until it handshakes.
    initial forever begin
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (hs_seen[p]) begin
                ptr[p]++;
                cur_valid[p] = 1'b0;
            end
            if (active[p] && ptr[p] >= plen[p]) active[p] = 1'b0;
            if (active[p] && !cur_valid[p])
                cur_valid[p] = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            axis_i_tvalid[p]             = cur_valid[p];
            axis_i_tdata[p*32 +: 32]     = (ptr[p] < 64) ? pdata[p][ptr[p]] : 32'h0;
            axis_i_tlast[p]              = cur_valid[p] && (ptr[p] == plen[p] - 1);
            axis_i_length_bytes[p*16 +: 16] = plen_bytes[p];
        end
        axis_o_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: tready exclusivity, len_err timing, bubble after tlast, beat scoreboard.
    initial forever begin
        logic [N-1:0] exp_mask;
        logic         exp_err;
        beat_t        e;
        @(negedge clk);
        exp_mask = (sb.size() > 0) ? (N'(1) << sb[0].port) : '0;
        tests_run++;
        if ((axis_i_tready & ~exp_mask) !== '0) begin
            tests_failed++;
            $display("FAIL tready_excl: got tready=%b, allowed mask=%b at cycle %0d",
                     axis_i_tready, exp_mask, cyc);
        end
        exp_err = pend_last ? pend_err : 1'b0;
        tests_run++;
        if (len_err !== exp_err) begin
            tests_failed++;
            $display("FAIL len_err: got %b, expected %b at cycle %0d", len_err, exp_err, cyc);
        end
        if (len_err === 1'b1) err_pulses++;
        if (pend_last) begin
            tests_run++;
            if ({busy, axis_o_tvalid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL bubble: got busy=%b tvalid=%b, expected 0 0 at cycle %0d",
                         busy, axis_o_tvalid, cyc);
            end
        end
        pend_last = 1'b0;
        if (axis_o_tvalid === 1'b1 && axis_o_tready === 1'b1) begin
            hs_log.push_back(cyc);
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL beat: got unexpected data=%h port=%0d, expected no beat",
                         axis_o_tdata, axis_o_port_id);
            end else begin
                e = sb.pop_front();
                if ({axis_o_tdata, axis_o_tlast, axis_o_port_id, axis_o_length_bytes} !==
                    {e.data, e.last, e.port, e.len}) begin
                    tests_failed++;
                    $display("FAIL beat: got data=%h last=%b port=%0d len=%0d, expected data=%h last=%b port=%0d len=%0d",
                             axis_o_tdata, axis_o_tlast, axis_o_port_id, axis_o_length_bytes,
                             e.data, e.last, e.port, e.len);
                end
                if (axis_o_tlast === 1'b1) begin
                    pend_last = 1'b1;
                    pend_err  = e.err;
                end
            end
        end
        hs_seen = axis_i_tvalid & axis_i_tready;
    end

    function automatic bit any_active();
        for (int p = 0; p < N; p++) if (active[p]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load_pkt(input int p, input int nbeats, input int len_bytes);
        beat_t e;
        plen[p]       = nbeats;
        plen_bytes[p] = 16'(len_bytes);
        ptr[p]        = 0;
        for (int i = 0; i < nbeats; i++) begin
            pdata[p][i] = $urandom;
            e.data = pdata[p][i];
            e.last = (i == nbeats - 1);
            e.port = 2'(p);
            e.len  = 16'(len_bytes);
            e.err  = (nbeats != (len_bytes + 3) / 4);
            sb.push_back(e);
        end
        active[p] = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || any_active()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests_run++;
            tests_failed++;
            $display("FAIL %s_timeout: got %0d beats outstanding after %0d cycles, expected 0",
                     name, sb.size(), budget);
            sb.delete();
            for (int p = 0; p < N; p++) active[p] = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        sresetn = 1'b0;
        axis_i_tvalid = '0;
        axis_i_tdata = '0;
        axis_i_tlast = '0;
        axis_i_length_bytes = '0;
        axis_o_tready = 1'b1;
        for (int p = 0; p < N; p++) begin
            plen[p] = 0; plen_bytes[p] = '0; ptr[p] = 0;
            active[p] = 1'b0; cur_valid[p] = 1'b0;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({axis_i_tready, axis_o_tvalid, busy, len_err} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got tready=%b tvalid=%b busy=%b len_err=%b, expected all 0",
                     axis_i_tready, axis_o_tvalid, busy, len_err);
        end
        tests_run++;
        if ({axis_o_length_bytes, axis_o_port_id} !== 18'b0) begin
            tests_failed++;
            $display("FAIL reset_meta: got len=%0d port=%0d, expected 0 0",
                     axis_o_length_bytes, axis_o_port_id);
        end
        sresetn = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({busy, axis_o_tvalid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL idle_no_req: got busy=%b tvalid=%b, expected 0 0", busy, axis_o_tvalid);
        end
    endtask

    task automatic test_multi();
        int base;
        int exp_gap [8] = '{1, 1, 2, 1, 1, 2, 1, 1};
        @(negedge clk); #1;
        base = hs_log.size();
        load_pkt(0, 3, 12);
        load_pkt(1, 3, 12);
        load_pkt(3, 3, 12);
        wait_drain("multi", 200);
        tests_run++;
        if (hs_log.size() - base != 9) begin
            tests_failed++;
            $display("FAIL multi_count: got %0d beats, expected 9", hs_log.size() - base);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (hs_log[base+i+1] - hs_log[base+i] != exp_gap[i]) begin
                    tests_failed++;
                    $display("FAIL multi_gap%0d: got %0d cycles, expected %0d",
                             i, hs_log[base+i+1] - hs_log[base+i], exp_gap[i]);
                end
            end
        end
    endtask

    task automatic test_single();
        int base, load_cyc, errs;
        @(negedge clk); #1;
        base = hs_log.size();
        errs = err_pulses;
        load_cyc = cyc;
        load_pkt(2, 5, 20);
        wait_drain("single", 100);
        tests_run++;
        if (hs_log.size() - base != 5) begin
            tests_failed++;
            $display("FAIL single_count: got %0d beats, expected 5", hs_log.size() - base);
        end else begin
            tests_run++;
            if (hs_log[base] - load_cyc != 2) begin
                tests_failed++;
                $display("FAIL single_latency: got first beat %0d cycles after load, expected 2",
                         hs_log[base] - load_cyc);
            end
        end
        tests_run++;
        if (err_pulses != errs || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_end: got err_pulses=%0d busy=%b, expected 0 0",
                     err_pulses - errs, busy);
        end
    endtask

    task automatic test_len_check();
        int errs;
        @(negedge clk); #1;
        errs = err_pulses;
        load_pkt(1, 6, 21);
        wait_drain("len_ok", 100);
        tests_run++;
        if (err_pulses != errs) begin
            tests_failed++;
            $display("FAIL len_ok: got %0d len_err pulses, expected 0", err_pulses - errs);
        end
        @(negedge clk); #1;
        errs = err_pulses;
        load_pkt(1, 5, 21);
        wait_drain("len_short", 100);
        tests_run++;
        if (err_pulses != errs + 1) begin
            tests_failed++;
            $display("FAIL len_short: got %0d len_err pulses, expected 1", err_pulses - errs);
        end
    endtask

    task automatic test_random_stall();
        int base;
        @(negedge clk); #1;
        base = hs_log.size();
        gaps = 1'b1;
        rand_ready = 1'b1;
        load_pkt(2, 12, 48);
        wait_drain("random", 1000);
        gaps = 1'b0;
        rand_ready = 1'b0;
        tests_run++;
        if (hs_log.size() - base != 12) begin
            tests_failed++;
            $display("FAIL random_count: got %0d beats, expected 12", hs_log.size() - base);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base, n;
        @(negedge clk); #1;
        base = hs_log.size();
        load_pkt(1, 8, 32);
        n = 0;
        while (hs_log.size() - base < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 100) begin
            tests_failed++;
            $display("FAIL resetmid_wait: got %0d beats, expected 3", hs_log.size() - base);
        end
        @(posedge clk); #2;
        sresetn = 1'b0;
        #1;
        tests_run++;
        if ({axis_i_tready, axis_o_tvalid, busy} !== 6'b0) begin
            tests_failed++;
            $display("FAIL resetmid_outputs: got tready=%b tvalid=%b busy=%b, expected 0",
                     axis_i_tready, axis_o_tvalid, busy);
        end
        active[1] = 1'b0;
        cur_valid[1] = 1'b0;
        ptr[1] = 0;
        axis_i_tvalid = '0;
        sb.delete();
        pend_last = 1'b0;
        repeat (2) @(negedge clk);
        sresetn = 1'b1;
        @(negedge clk); #1;
        load_pkt(0, 2, 8);
        load_pkt(2, 2, 8);
        wait_drain("resetmid_after", 100);
    endtask

    task automatic test_rotation();
        int base;
        @(negedge clk); #1;
        load_pkt(3, 2, 8);
        wait_drain("rot_first", 100);
        @(negedge clk); #1;
        base = hs_log.size();
        load_pkt(0, 2, 8);
        load_pkt(3, 2, 8);
        wait_drain("rot_pair", 100);
        tests_run++;
        if (hs_log.size() - base != 4) begin
            tests_failed++;
            $display("FAIL rot_count: got %0d beats, expected 4", hs_log.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_multi();
        test_single();
        test_len_check();
        test_random_stall();
        test_reset_mid();
        test_rotation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
